// File: rtl/window_cache_if.sv
// Load/shift/clear command bus and window output bus for window_cache.
// Ports: master drives ld_en/ld_row/ld_seg/ld_data, shk_en, clr_en and reads the window;
//        slave (the cache) reads the commands and drives win_data, cell_valid, win_valid, ld_err, shk_cnt.
interface window_cache_if #(
  parameter int PW   = 24,
  parameter int ROWS = 3,
  parameter int COLS = 4,
  parameter int SEG  = 2
);
  // Index widths are derived from the geometry and never set directly.
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = ((COLS / SEG) > 1) ? $clog2(COLS / SEG) : 1;

  logic                     ld_en;
  logic [RW-1:0]            ld_row;
  logic [SW-1:0]            ld_seg;
  logic [SEG*PW-1:0]        ld_data;
  logic                     shk_en;
  logic                     clr_en;
  logic [ROWS*COLS*PW-1:0]  win_data;
  logic [ROWS*COLS-1:0]     cell_valid;
  logic                     win_valid;
  logic                     ld_err;
  logic [7:0]               shk_cnt;

  modport master (
    output ld_en, ld_row, ld_seg, ld_data, shk_en, clr_en,
    input  win_data, cell_valid, win_valid, ld_err, shk_cnt
  );

  modport slave (
    input  ld_en, ld_row, ld_seg, ld_data, shk_en, clr_en,
    output win_data, cell_valid, win_valid, ld_err, shk_cnt
  );
endinterface

// File: rtl/window_cache.sv
// ROWS x COLS pixel-window cache: segment loads, slide-left-one-column shifts, per-cell validity.
// Ports: clk, rst (async active-low), bus (slave modport of window_cache_if); every operation
//        is visible one cycle after the edge that samples it, no backpressure, one op of each kind per cycle.
module window_cache #(
  parameter int PW   = 24,
  parameter int ROWS = 3,
  parameter int COLS = 4,
  parameter int SEG  = 2
) (
  input  logic           clk,
  input  logic           rst,
  window_cache_if.slave  bus
);
  localparam int NC   = ROWS * COLS;
  localparam int NSEG = COLS / SEG;

  // Cell (r,c) lives at index r*COLS+c, so the packed array is already the win_data layout.
  logic [NC-1:0][PW-1:0] pix_q, pix_d;
  logic [NC-1:0]         vld_q, vld_d;
  logic                  win_vld_q;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ld_bad;

  always_comb begin
    ld_bad = (int'(bus.ld_row) >= ROWS) || (int'(bus.ld_seg) >= NSEG);
  end

  always_comb begin
    pix_d = pix_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (bus.clr_en) begin
      // Clear wins outright; any strobe alongside it is dropped, including reject reporting.
      pix_d = '0;
      vld_d = '0;
      cnt_d = '0;
    end else begin
      if (bus.shk_en) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS - 1; c++) begin
            pix_d[r*COLS+c] = pix_q[r*COLS+c+1];
            vld_d[r*COLS+c] = vld_q[r*COLS+c+1];
          end
          pix_d[r*COLS+COLS-1] = '0;
          vld_d[r*COLS+COLS-1] = 1'b0;
        end
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // The load lands on the post-shift image, so it overrides shifted-in data or zero fill.
      if (bus.ld_en) begin
        if (ld_bad) begin
          err_d = 1'b1;
        end else begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if ((r == int'(bus.ld_row)) && ((c / SEG) == int'(bus.ld_seg))) begin
                pix_d[r*COLS+c] = bus.ld_data[(c % SEG)*PW +: PW];
                vld_d[r*COLS+c] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q     <= '0;
      vld_q     <= '0;
      win_vld_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pix_q     <= pix_d;
      vld_q     <= vld_d;
      // Reduced from next-state so win_valid never lags cell_valid by a cycle.
      win_vld_q <= &vld_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.win_data   = pix_q;
  assign bus.cell_valid = vld_q;
  assign bus.win_valid  = win_vld_q;
  assign bus.ld_err     = err_q;
  assign bus.shk_cnt    = cnt_q;
endmodule

// File: tb/tb_window_cache.sv
// Randomized plus directed bench for window_cache against a 2-D array reference model.
// Ports: none; instantiates window_cache_if and window_cache, drives clk and rst.
module tb_window_cache;
  localparam int PW   = 24;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int SEG  = 2;
  localparam int NW   = ROWS * COLS * PW;
  localparam int NC   = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  window_cache_if #(.PW(PW), .ROWS(ROWS), .COLS(COLS), .SEG(SEG)) bus ();

  window_cache #(.PW(PW), .ROWS(ROWS), .COLS(COLS), .SEG(SEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [PW-1:0] mpix [ROWS][COLS];
  bit            mvld [ROWS][COLS];
  bit            merr;
  int            mcnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        mpix[r][c] = '0;
        mvld[r][c] = 1'b0;
      end
    merr = 1'b0;
    mcnt = 0;
  endtask

  task automatic m_apply(input bit clr, input bit shk, input bit ld, input int row, input int seg,
                         input logic [SEG*PW-1:0] data);
    merr = 1'b0;
    if (clr) begin
      m_reset();
      return;
    end
    if (shk) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS - 1; c++) begin
          mpix[r][c] = mpix[r][c+1];
          mvld[r][c] = mvld[r][c+1];
        end
        mpix[r][COLS-1] = '0;
        mvld[r][COLS-1] = 1'b0;
      end
      if (mcnt < 255) mcnt++;
    end
    if (ld) begin
      if (row >= ROWS || seg >= COLS / SEG) merr = 1'b1;
      else
        for (int k = 0; k < SEG; k++) begin
          mpix[row][seg*SEG+k] = data[k*PW +: PW];
          mvld[row][seg*SEG+k] = 1'b1;
        end
    end
  endtask

  function automatic logic [NW-1:0] m_win();
    logic [NW-1:0] w = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        w[(r*COLS+c)*PW +: PW] = mpix[r][c];
    return w;
  endfunction

  function automatic logic [NC-1:0] m_vld();
    logic [NC-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS+c] = mvld[r][c];
    return v;
  endfunction

  task automatic check_all(input string tag);
    logic [NC-1:0] v;
    v = m_vld();
    chk({tag, ".win_data"},   NW'(bus.win_data),   NW'(m_win()));
    chk({tag, ".cell_valid"}, NW'(bus.cell_valid), NW'(v));
    chk({tag, ".win_valid"},  NW'(bus.win_valid),  NW'(&v));
    chk({tag, ".ld_err"},     NW'(bus.ld_err),     NW'(merr));
    chk({tag, ".shk_cnt"},    NW'(bus.shk_cnt),    NW'(mcnt));
  endtask

  // Drive one cycle of strobes, clock it, update the model, return strobes to idle.
  task automatic op(input string tag, input bit clr, input bit shk, input bit ld,
                    input logic [1:0] row, input logic seg, input logic [SEG*PW-1:0] data);
    bus.clr_en  = clr;
    bus.shk_en  = shk;
    bus.ld_en   = ld;
    bus.ld_row  = row;
    bus.ld_seg  = seg;
    bus.ld_data = data;
    @(posedge clk);
    #1;
    m_apply(clr, shk, ld, int'(row), int'(seg), data);
    bus.clr_en = 1'b0;
    bus.shk_en = 1'b0;
    bus.ld_en  = 1'b0;
    // Scramble idle inputs: without a strobe they must not matter.
    bus.ld_row  = 2'($urandom);
    bus.ld_seg  = 1'($urandom);
    bus.ld_data = {$urandom, $urandom};
    check_all(tag);
  endtask

  function automatic logic [SEG*PW-1:0] ramp(input int r, input int s);
    logic [SEG*PW-1:0] d = '0;
    for (int k = 0; k < SEG; k++)
      d[k*PW +: PW] = PW'(16 * r + s * SEG + k);
    return d;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < ROWS; r++)
      for (int s = 0; s < COLS / SEG; s++)
        op("fill", 1'b0, 1'b0, 1'b1, 2'(r), 1'(s), ramp(r, s));
  endtask

  initial begin
    bus.ld_en   = 1'b0;
    bus.shk_en  = 1'b0;
    bus.clr_en  = 1'b0;
    bus.ld_row  = '0;
    bus.ld_seg  = '0;
    bus.ld_data = '0;
    m_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Six ramp loads complete the window.
    fill_ramp();
    chk("full.win_valid", NW'(bus.win_valid), NW'(1));
    chk("full.pix23", NW'(bus.win_data[(2*COLS+3)*PW +: PW]), NW'(24'h000023));
    chk("full.cnt", NW'(bus.shk_cnt), NW'(0));

    // Shifts on a full window.
    op("shift1", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0);
    chk("shift1.vld", NW'(bus.cell_valid), NW'(12'h777));
    chk("shift1.pix02", NW'(bus.win_data[2*PW +: PW]), NW'(24'h000003));
    chk("shift1.cnt", NW'(bus.shk_cnt), NW'(1));
    op("shift2", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0);
    chk("shift2.vld", NW'(bus.cell_valid), NW'(12'h333));

    // Shift and load together on a refilled window.
    fill_ramp();
    op("shkld", 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, {24'hBBBBBB, 24'hAAAAAA});
    chk("shkld.pix12", NW'(bus.win_data[(1*COLS+2)*PW +: PW]), NW'(24'hAAAAAA));
    chk("shkld.pix13", NW'(bus.win_data[(1*COLS+3)*PW +: PW]), NW'(24'hBBBBBB));
    chk("shkld.vld", NW'(bus.cell_valid), NW'(12'h7F7));

    // Rejected row with a shift: no write, error pulse, shift still taken.
    op("rej", 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, {24'h123456, 24'h654321});
    chk("rej.err", NW'(bus.ld_err), NW'(1));
    op("rej2", 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, '0);
    chk("rej2.err", NW'(bus.ld_err), NW'(1));
    op("rej.idle", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0);
    chk("rej.idle.err", NW'(bus.ld_err), NW'(0));

    // Clear dominates everything.
    op("clr", 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, {24'h111111, 24'h222222});
    chk("clr.win", bus.win_data, '0);
    chk("clr.cnt", NW'(bus.shk_cnt), NW'(0));
    chk("clr.err", NW'(bus.ld_err), NW'(0));

    // Counter saturation.
    for (int i = 0; i < 260; i++)
      op("sat", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0);
    chk("sat.cnt", NW'(bus.shk_cnt), NW'(255));

    // Random mix.
    for (int i = 0; i < 1500; i++)
      op("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
         ($urandom_range(0, 1) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
         {$urandom, $urandom});

    // Asynchronous reset mid-cycle after a partial load.
    op("clr2", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0);
    op("part", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, {24'hCAFE01, 24'hBEEF02});
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1'b1;
    op("post", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, {24'h0000AB, 24'h0000CD});
    chk("post.pix03", NW'(bus.win_data[3*PW +: PW]), NW'(24'h0000AB));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/window_cache.md
# window_cache

Parametrised pixel-window cache for the kernel (convolution) datapath. Holds a ROWS x COLS window of pixels, loaded SEG pixels at a time by LDK-style writes and slid left one column per SHK-style shift. It tracks per-cell validity so the kernel unit knows when a complete window is present, and it exposes the full window as one flat registered bus. It sits between data memory (load path) and the kernel ALU.

## Interface
- PW, 24: pixel word width in bits
- ROWS, 3: window rows
- COLS, 4: window columns; must be a multiple of SEG
- SEG, 2: pixels written per load beat
- RW = $clog2(ROWS) (min 1), SW = $clog2(COLS/SEG) (min 1): derived, not overridable

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ld_en  in  1  load strobe
- ld_row  in  RW  target row
- ld_seg  in  SW  target segment; columns ld_seg*SEG .. ld_seg*SEG+SEG-1
- ld_data  in  SEG*PW  pixel k at bits [k*PW +: PW] goes to column ld_seg*SEG+k
- shk_en  in  1  shift-left-one-column strobe
- clr_en  in  1  synchronous clear of window and validity
- win_data  out  ROWS*COLS*PW  pixel (r,c) at bits [(r*COLS+c)*PW +: PW]
- cell_valid  out  ROWS*COLS  bit r*COLS+c set when pixel (r,c) holds loaded data
- win_valid  out  1  high when every cell_valid bit is 1
- ld_err  out  1  one-cycle pulse for a rejected load
- shk_cnt  out  8  shifts since last clear/reset, saturating at 255

## Operation
- Storage: ROWS*COLS registers of PW bits plus one valid bit each; win_data and cell_valid drive directly from these registers.
- Priority per cycle: clr_en > (shk_en then ld_en).
- clr_en=1: all pixels 0, all valid 0, shk_cnt 0; shk_en and ld_en ignored that cycle; ld_err stays 0.
- shk_en=1: for each row, column c takes column c+1 (pixel and valid), c = 0..COLS-2; column COLS-1 becomes pixel 0, valid 0. shk_cnt increments, holding at 255.
- ld_en=1: writes SEG pixels into (ld_row, segment ld_seg) and sets their valid bits.
- shk_en and ld_en in the same cycle: shift is applied first, then the load writes into the post-shift positions. The load's cells end valid with ld_data, overriding shifted-in data or zero fill.
- Rejected load: ld_row >= ROWS or ld_seg >= COLS/SEG. No storage write and ld_err=1 next cycle; a simultaneous shift still executes.
- win_valid is the AND-reduction of the next-state valid bits, registered, so it is always consistent with cell_valid in the same cycle.
- Any input change without a strobe leaves state unchanged.

## Timing
- Reset (rst=0, asynchronous): win_data=0, cell_valid=0, win_valid=0, ld_err=0, shk_cnt=0, held until rst=1. The first active edge after deassertion may carry operations.
- Reset asserted mid-operation aborts any in-flight effect; no partial write is visible.
- Latency: an operation sampled on edge N is visible on all outputs after edge N, i.e. one cycle. No busy state; one operation of each kind accepted every cycle.
- ld_err is high exactly one cycle per rejected load; back-to-back rejects keep it high.
- The window is full after ROWS*COLS/SEG valid loads (6 at defaults). win_valid rises in the cycle the last missing cell is loaded.
- A shift on a full window drops win_valid (rightmost column invalid). A load+shift in the same cycle that refills the rightmost column in every row is not possible with one load port when ROWS>1. Refill of the rightmost column takes ROWS load cycles.

## Test plan
- Reset then 6 loads (rows 0..2, segs 0..1, pixel value = 0x10*r + c) -> win_valid=1 after 6th edge; win_data pixel (2,3)=0x000023; shk_cnt=0.
- Full window, shk_en once -> pixel (r,c)=old (r,c+1) for c<3, column 3 pixel=0 and valid=0, win_valid=0, shk_cnt=1. A second shift clears columns 2..3.
- Same-cycle shk_en+ld_en (row 1, seg 1, data 0xAAAAAA/0xBBBBBB) on full window -> (1,2)=0xAAAAAA, (1,3)=0xBBBBBB valid; rows 0,2 col 3 invalid.
- ld_row=3 with ld_en and shk_en -> no write, ld_err=1 for one cycle, shift applied, shk_cnt incremented.
- clr_en with ld_en and shk_en asserted -> all outputs 0 next cycle, including shk_cnt. 260 consecutive shifts -> shk_cnt holds at 255.
- rst pulled low asynchronously mid-cycle after a partial load -> outputs 0 immediately, before the next edge. A load on the first edge after release works normally.
